imm_extend_seq: RTL and testbench

//  Parametrised, handshaked immediate generator; next generation of the combinational extender.

---
 rtl/imm_extend_seq.sv | 135 +++++++++++++
 tb/tb_imm_extend_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_seq.sv
// Handshaked immediate generator: rotated imm8, zext/sext imm12 and shifted branch offsets.
// Optional rotator carry output is enabled by defining IMM_EXT_CARRY_EN.
module imm_extend_seq #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ROT_STEP = 2,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       instr,
  input  logic [1:0]        imm_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_imm
`ifdef IMM_EXT_CARRY_EN
  ,
  output logic              carry_out
`endif
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(ROT_STEP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROTATE,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  work_q, work_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q, out_valid_d;
`ifdef IMM_EXT_CARRY_EN
  logic               carry_q, carry_d;
`endif

  logic               accept;
  logic [DATA_W-1:0]  load_val;
  logic [CNT_W-1:0]   load_cnt;
  logic [CNT_W-1:0]   step;
  logic [DATA_W-1:0]  rot_val;

  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] w,
                                            input logic [CNT_W-1:0]  s);
    logic [2*DATA_W-1:0] dbl;
    dbl = {w, w} >> s;
    return dbl[DATA_W-1:0];
  endfunction

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Pre-rotation operand and rotate count for the incoming op
  always_comb begin
    load_val = '0;
    load_cnt = '0;
    unique case (imm_src)
      2'b00: begin
        load_val = DATA_W'(instr[7:0]);
        load_cnt = {instr[11:8], 1'b0};
      end
      2'b01:   load_val = DATA_W'(instr[11:0]);
      2'b10:   load_val = {{(DATA_W-24){instr[23]}}, instr} << BR_SHIFT;
      default: load_val = {{(DATA_W-12){instr[11]}}, instr[11:0]};
    endcase
  end

  assign step    = (count_q < STEP_MAX) ? count_q : STEP_MAX;
  assign rot_val = ror(work_q, step);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
`ifdef IMM_EXT_CARRY_EN
    carry_d = carry_q;
`endif
    unique case (state_q)
      ST_ROTATE: begin
        work_d  = rot_val;
        count_d = count_q - step;
        if (count_d == '0) begin
          state_d = ST_DONE;
`ifdef IMM_EXT_CARRY_EN
          carry_d = rot_val[DATA_W-1];
`endif
        end
      end
      ST_DONE: begin
        if (out_ready && !accept) state_d = ST_IDLE;
      end
      default: ;
    endcase
    // A completing transfer may be replaced by a new op in the same cycle
    if (accept) begin
      work_d  = load_val;
      count_d = load_cnt;
      state_d = (load_cnt == '0) ? ST_DONE : ST_ROTATE;
`ifdef IMM_EXT_CARRY_EN
      carry_d = 1'b0;
`endif
    end
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef IMM_EXT_CARRY_EN
      carry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
`ifdef IMM_EXT_CARRY_EN
      carry_q     <= carry_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign ext_imm   = work_q;
`ifdef IMM_EXT_CARRY_EN
  assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_imm_extend_seq.sv
// Self-checking bench for imm_extend_seq: directed vectors, handshake corners and a random model run.
module tb_imm_extend_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] instr;
  logic [1:0]  imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ext_imm;
`ifdef IMM_EXT_CARRY_EN
  logic        carry_out;
`endif

  int total = 0;
  int bad   = 0;

  imm_extend_seq #(.DATA_W(32), .ROT_STEP(2), .BR_SHIFT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_src(imm_src), .out_valid(out_valid),
    .out_ready(out_ready), .ext_imm(ext_imm)
`ifdef IMM_EXT_CARRY_EN
    , .carry_out(carry_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    logic [23:0] ins;
    logic [31:0] exp;
    logic        cy;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Reference model straight from the mode rules, using plain integer arithmetic
  function automatic logic [31:0] ref_val(input logic [1:0] src, input logic [23:0] ins);
    longint v, r, lo12, full;
    lo12 = longint'(ins) % 4096;
    full = longint'(ins);
    case (src)
      2'd0: begin
        v = longint'(ins) % 256;
        r = 2 * ((longint'(ins) / 256) % 16);
        return 32'(((v >> r) | (v << (32 - r))) % (64'd1 << 32));
      end
      2'd1: return 32'(lo12);
      2'd2: begin
        if (full >= 8388608) full = full - 16777216;
        return 32'((full * 4) & 64'hFFFF_FFFF);
      end
      default: begin
        if (lo12 >= 2048) lo12 = lo12 - 4096;
        return 32'(lo12 & 64'hFFFF_FFFF);
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] src, input logic [23:0] ins);
    int rot;
    rot = (int'(ins) / 256) % 16;
    if (src != 2'd0) return 1;
    return 1 + (2 * rot + 1) / 2;
  endfunction

  function automatic logic ref_cy(input logic [1:0] src, input logic [23:0] ins);
    logic [31:0] v;
    v = ref_val(src, ins);
    return (src == 2'd0) && (((int'(ins) / 256) % 16) != 0) && (v >= 32'h8000_0000);
  endfunction

  // One op from IDLE: latency, value, hold under stall, and return to IDLE
  task automatic do_op(input string nm, input vec_t v, input int stall);
    int k;
    logic hold_err;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; imm_src = v.src; instr = v.ins; out_ready = 1'b0;
    step_clk();
    in_valid = 1'b0;
    instr = 24'(~v.ins);
    k = 0;
    while (!out_valid && k < 60) begin
      step_clk();
      k++;
    end
    chk({nm, "_latency"}, 32'(k + (out_valid ? 1 : 0)), 32'(v.lat));
    chk({nm, "_value"}, ext_imm, v.exp);
`ifdef IMM_EXT_CARRY_EN
    chk({nm, "_carry"}, 32'(carry_out), 32'(v.cy));
`endif
    hold_err = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      step_clk();
      if (!out_valid || ext_imm !== v.exp || in_ready) hold_err = 1'b1;
    end
    in_valid = 1'b0;
    if (stall > 0) chk({nm, "_hold"}, 32'(hold_err), 32'd0);
    out_ready = 1'b1;
    step_clk();
    out_ready = 1'b0;
    chk({nm, "_drop_valid"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic seen;
    vec_t rv;
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; imm_src = '0; out_ready = 1'b0;

    // Reset held for two clocks
    step_clk();
    step_clk();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ext_imm", ext_imm, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef IMM_EXT_CARRY_EN
    chk("rst_carry", 32'(carry_out), 32'd0);
`endif
    rst_n = 1'b1;
    step_clk();

    vecs.push_back('{2'd0, 24'h0004FF, 32'hFF00_0000, 1'b1, 5});
    vecs.push_back('{2'd0, 24'h0000FF, 32'h0000_00FF, 1'b0, 1});
    vecs.push_back('{2'd0, 24'h0001F1, 32'h4000_003C, 1'b0, 2});
    vecs.push_back('{2'd0, 24'h0001FF, 32'hC000_003F, 1'b1, 2});
    vecs.push_back('{2'd0, 24'h000F01, 32'h0000_0004, 1'b0, 16});
    vecs.push_back('{2'd2, 24'hFFFFFE, 32'hFFFF_FFF8, 1'b0, 1});
    vecs.push_back('{2'd2, 24'h000010, 32'h0000_0040, 1'b0, 1});
    vecs.push_back('{2'd1, 24'h000ABC, 32'h0000_0ABC, 1'b0, 1});
    vecs.push_back('{2'd1, 24'hFFFABC, 32'h0000_0ABC, 1'b0, 1});
    vecs.push_back('{2'd3, 24'h000800, 32'hFFFF_F800, 1'b0, 1});
    vecs.push_back('{2'd3, 24'h0007FF, 32'h0000_07FF, 1'b0, 1});
    foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i], (i % 2 == 0) ? 0 : 2);

    // Backpressure: three stalled cycles with in_valid asserted, then replace on transfer
    in_valid = 1'b1; imm_src = 2'd1; instr = 24'h000123; out_ready = 1'b0;
    step_clk();
    imm_src = 2'd3; instr = 24'h000FFF;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_value%0d", i), ext_imm, 32'h0000_0123);
      chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    imm_src = 2'd1; instr = 24'h000ABC; out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(in_ready), 32'd1);
    step_clk();
    in_valid = 1'b0;
    chk("bp_new_valid", 32'(out_valid), 32'd1);
    chk("bp_new_value", ext_imm, 32'h0000_0ABC);
    step_clk();
    out_ready = 1'b0;
    chk("bp_idle", 32'(out_valid), 32'd0);

    // Back-to-back zero-latency ops at one result per cycle
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imm_src = 2'd1; instr = 24'(12'h111 * (i + 1));
      step_clk();
      chk($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b_value%0d", i), ext_imm, 32'(12'h111 * (i + 1)));
    end
    in_valid = 1'b0;
    step_clk();
    out_ready = 1'b0;
    chk("b2b_idle", 32'(out_valid), 32'd0);

    // Reset in the middle of a long rotation drops the op
    in_valid = 1'b1; imm_src = 2'd0; instr = 24'h000F01;
    step_clk();
    in_valid = 1'b0;
    step_clk();
    step_clk();
    rst_n = 1'b0;
    step_clk();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_value", ext_imm, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step_clk();
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_ghost", 32'(seen), 32'd0);

    // Random ops against the model
    for (int n = 0; n < 120; n++) begin
      rv.src = 2'($urandom_range(0, 3));
      rv.ins = 24'($urandom);
      rv.exp = ref_val(rv.src, rv.ins);
      rv.cy  = ref_cy(rv.src, rv.ins);
      rv.lat = ref_lat(rv.src, rv.ins);
      do_op($sformatf("rnd%0d", n), rv, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
